// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone responder memory.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } wb_state_t;

  // Width of the wait-state down-counter (WAIT_STATES up to 15).
  localparam int WAIT_CNT_W = 4;

  // Number of low byte-address bits that select a lane inside a word.
  function automatic int lane_bits(input int strb_w);
    return (strb_w > 1) ? $clog2(strb_w) : 0;
  endfunction

endpackage

// File: rtl/wb_bytemem.sv
// Word-organised storage with per-lane write enables, registered read
// and a full synchronous clear on reset.
module wb_bytemem
  import wb_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     addr,
  input  logic              wr_en,
  input  logic [STRB_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: clear every word on reset, otherwise write enabled lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_sel[b]) begin
          mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read port: capture the addressed word only when asked, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_resp_mem.sv
// Wishbone classic-cycle responder with programmable wait states in front
// of a byte-writable memory. Transfer attributes are frozen at accept;
// the acknowledge and read data are driven from an output register one
// cycle after the FSM reaches ACK.
module wb_resp_mem
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic [STRB_W-1:0] wb_sel_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o
);

  localparam int LANE   = lane_bits(STRB_W);
  localparam int IDX_W  = ADDR_W - LANE;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_I = (IDX_W + 1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  wb_state_t state, state_nx;
  logic [WAIT_CNT_W-1:0] cnt;

  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [STRB_W-1:0] sel_q;
  logic [DATA_W-1:0] dat_q;

  logic              req;
  logic              accept;
  logic              enter_ack;
  logic [IDX_W-1:0]  xfer_idx;
  logic              xfer_we;
  logic [STRB_W-1:0] xfer_sel;
  logic [DATA_W-1:0] xfer_dat;
  logic              in_range;
  logic              rd_hit;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  assign req    = wb_cyc_i & wb_stb_i;
  assign accept = (state == S_IDLE) && req;

  // Sub-word address bits carry no meaning for a word-wide target.
  if (LANE > 0) begin : g_lane_bits
    logic unused_lane_bits;
    assign unused_lane_bits = &{1'b0, wb_adr_i[LANE-1:0]};
  end

  // Next-state logic; a dropped cycle during WAIT abandons the transfer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nx = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_nx = S_IDLE;
        end else if (cnt == '0) begin
          state_nx = S_ACK;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign enter_ack = (state_nx == S_ACK);

  // Zero-wait transfers reach ACK on the accept edge, before the latch
  // holds anything, so the live bus is used from IDLE.
  always_comb begin
    xfer_idx = idx_q;
    xfer_we  = we_q;
    xfer_sel = sel_q;
    xfer_dat = dat_q;
    if (state == S_IDLE) begin
      xfer_idx = wb_adr_i[ADDR_W-1:LANE];
      xfer_we  = wb_we_i;
      xfer_sel = wb_sel_i;
      xfer_dat = wb_dat_i;
    end
  end

  assign in_range  = {1'b0, xfer_idx} < DEPTH_I;
  assign mem_wr_en = enter_ack & xfer_we & in_range & ~reset;
  assign mem_rd_en = enter_ack & ~xfer_we & in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Wait-state down-counter, loaded at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= WS_LOAD;
    end else if ((state == S_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request latch: freeze the transfer attributes at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (accept) begin
      idx_q <= wb_adr_i[ADDR_W-1:LANE];
      we_q  <= wb_we_i;
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
    end
  end

  // Remember whether the word captured on entry to ACK is a valid read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hit <= 1'b0;
    end else if (enter_ack) begin
      rd_hit <= ~xfer_we & in_range;
    end
  end

  // Output register: one-cycle ack, data forced to zero outside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= (state == S_ACK);
      wb_dat_o <= ((state == S_ACK) && rd_hit) ? mem_rdata : '0;
    end
  end

  wb_bytemem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .STRB_W (STRB_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .addr    (xfer_idx[MEM_AW-1:0]),
    .wr_en   (mem_wr_en),
    .wr_sel  (xfer_sel),
    .wr_data (xfer_dat),
    .rd_en   (mem_rd_en),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_wb_resp_mem.sv
// Self-checking bench: three responders (0, 3 and 4 wait states) share the
// address/data bus, each with its own cyc/stb. Expected read data goes into
// a queue when a read is issued and is popped when its ack arrives.
module tb_wb_resp_mem;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [31:0] dat;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  ack;
  logic [31:0] dout [3];

  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          d;
    logic        w;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] ex;
    int          lat;
  } step_t;

  always #5 clk = ~clk;

  wb_resp_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we),
    .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_sel_i(sel),
    .wb_dat_o(dout[0]), .wb_ack_o(ack[0]));

  wb_resp_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we),
    .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_sel_i(sel),
    .wb_dat_o(dout[1]), .wb_ack_o(ack[1]));

  wb_resp_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(4)) u_ws4 (
    .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we),
    .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]), .wb_sel_i(sel),
    .wb_dat_o(dout[2]), .wb_ack_o(ack[2]));

  // One transfer on responder d. lat = negedge index (1 = cycle after the
  // accept edge) of the first ack, -1 if none within the budget. The bus is
  // scrambled right after accept so a missing request latch shows up.
  task automatic xfer(input int d, input logic w, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rd, output int lat,
                      output int nack, output int leak);
    @(negedge clk);
    adr = a; dat = wd; we = w; sel = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    #1;
    adr = ~a; dat = ~wd; we = ~w; sel = ~s;
    lat = -1; nack = 0; leak = 0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[d]) begin
        nack++;
        if (lat < 0) begin
          lat = n;
          rd  = dout[d];
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end else if (dout[d] !== 32'h0) begin
        leak++;
      end
      if (lat >= 0 && n >= lat + 3) break;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    int lat, nack, leak;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ack[i] !== 1'b0) begin
        errors++; $display("FAIL reset_ack[%0d] got %0b want 0", i, ack[i]);
      end
      checks++;
      if (dout[i] !== 32'h0) begin
        errors++; $display("FAIL reset_dat[%0d] got %08h want 00000000", i, dout[i]);
      end
    end
    reset = 1'b0;
    exp_q.push_back(32'h0);
    xfer(1, 1'b0, 16'h0040, 32'h0, 4'hF, rd, lat, nack, leak);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL reset_mem_clear got %08h want %08h", rd, ex);
    end
  endtask

  task automatic test_ws0_transfers();
    step_t tbl[$];
    logic [31:0] rd, ex;
    int lat, nack, leak;
    tbl.push_back('{"wr_beef",      0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0,        2});
    tbl.push_back('{"rd_beef",      0, 1'b0, 16'h0010, 32'h0,        4'hF, 32'hDEADBEEF, 2});
    tbl.push_back('{"rd_beef_lowa", 0, 1'b0, 16'h0013, 32'h0,        4'h0, 32'hDEADBEEF, 2});
    tbl.push_back('{"wr_ones",      0, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 32'h0,        2});
    tbl.push_back('{"wr_sel5",      0, 1'b1, 16'h0020, 32'h00000000, 4'h5, 32'h0,        2});
    tbl.push_back('{"rd_sel5",      0, 1'b0, 16'h0020, 32'h0,        4'hF, 32'hFF00FF00, 2});
    tbl.push_back('{"wr_sel0",      0, 1'b1, 16'h0020, 32'h12345678, 4'h0, 32'h0,        2});
    tbl.push_back('{"rd_sel0",      0, 1'b0, 16'h0020, 32'h0,        4'hF, 32'hFF00FF00, 2});
    tbl.push_back('{"wr_oor",       0, 1'b1, 16'(DEPTH*4), 32'h12345678, 4'hF, 32'h0,    2});
    tbl.push_back('{"rd_oor",       0, 1'b0, 16'(DEPTH*4), 32'h0,    4'hF, 32'h0,        2});
    tbl.push_back('{"rd_word0",     0, 1'b0, 16'h0000, 32'h0,        4'hF, 32'h0,        2});
    foreach (tbl[i]) begin
      if (!tbl[i].w) exp_q.push_back(tbl[i].ex);
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, rd, lat, nack, leak);
      checks++;
      if (lat !== tbl[i].lat) begin
        errors++; $display("FAIL %s latency got %0d want %0d", tbl[i].tag, lat, tbl[i].lat);
      end
      checks++;
      if (nack !== 1) begin
        errors++; $display("FAIL %s ack_cycles got %0d want 1", tbl[i].tag, nack);
      end
      checks++;
      if (leak !== 0) begin
        errors++; $display("FAIL %s dat_outside_ack got %0d want 0", tbl[i].tag, leak);
      end
      if (!tbl[i].w) begin
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin
          errors++; $display("FAIL %s rdata got %08h want %08h", tbl[i].tag, rd, ex);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    step_t tbl[$];
    logic [31:0] rd, ex;
    int lat, nack, leak;
    tbl.push_back('{"ws3_wr",     1, 1'b1, 16'h0004, 32'hCAFEF00D, 4'hF, 32'h0,        5});
    tbl.push_back('{"ws3_rd",     1, 1'b0, 16'h0004, 32'h0,        4'hF, 32'hCAFEF00D, 5});
    tbl.push_back('{"ws3_wr_lo",  1, 1'b1, 16'h0004, 32'h00000000, 4'h3, 32'h0,        5});
    tbl.push_back('{"ws3_rd_lo",  1, 1'b0, 16'h0004, 32'h0,        4'hF, 32'hCAFE0000, 5});
    tbl.push_back('{"ws4_wr",     2, 1'b1, 16'h0018, 32'h76543210, 4'hF, 32'h0,        6});
    tbl.push_back('{"ws4_rd",     2, 1'b0, 16'h0018, 32'h0,        4'hF, 32'h76543210, 6});
    foreach (tbl[i]) begin
      if (!tbl[i].w) exp_q.push_back(tbl[i].ex);
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, rd, lat, nack, leak);
      checks++;
      if (lat !== tbl[i].lat) begin
        errors++; $display("FAIL %s latency got %0d want %0d", tbl[i].tag, lat, tbl[i].lat);
      end
      checks++;
      if (nack !== 1) begin
        errors++; $display("FAIL %s ack_cycles got %0d want 1", tbl[i].tag, nack);
      end
      if (!tbl[i].w) begin
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin
          errors++; $display("FAIL %s rdata got %08h want %08h", tbl[i].tag, rd, ex);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, ex;
    int lat, nack, leak;
    @(negedge clk);
    adr = 16'h0008; dat = 32'hA5A5A5A5; we = 1'b1; sel = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    nack = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2]) nack++;
    end
    checks++;
    if (nack !== 0) begin
      errors++; $display("FAIL abort_ack got %0d acks want 0", nack);
    end
    exp_q.push_back(32'h0);
    xfer(2, 1'b0, 16'h0008, 32'h0, 4'hF, rd, lat, nack, leak);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL abort_rdata got %08h want %08h", rd, ex);
    end
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL abort_rd_latency got %0d want 6", lat);
    end
  endtask

  // Write then read held back-to-back with cyc/stb never dropping.
  task automatic test_back_to_back();
    logic [31:0] rd, ex;
    int first, second, nack, consec;
    logic prev;
    first = -1; second = -1; nack = 0; consec = 0; prev = 1'b0; rd = '0;
    exp_q.push_back(32'h0BADF00D);
    @(negedge clk);
    adr = 16'h0030; dat = 32'h0BADF00D; we = 1'b1; sel = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack[0]) begin
        nack++;
        if (prev) consec++;
        if (first < 0) begin
          first = n;
          we = 1'b0; dat = 32'h0;
        end else if (second < 0) begin
          second = n;
          rd = dout[0];
          cyc[0] = 1'b0; stb[0] = 1'b0;
        end
      end
      prev = ack[0];
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    checks++;
    if (first !== 2) begin
      errors++; $display("FAIL b2b_first_ack got %0d want 2", first);
    end
    checks++;
    if (second !== 4) begin
      errors++; $display("FAIL b2b_second_ack got %0d want 4", second);
    end
    checks++;
    if (nack !== 2 || consec !== 0) begin
      errors++; $display("FAIL b2b_ack_pattern got acks=%0d consec=%0d want acks=2 consec=0", nack, consec);
    end
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL b2b_raw_rdata got %08h want %08h", rd, ex);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ex;
    int lat, nack, leak;
    exp_q.push_back(32'h11111111);
    xfer(0, 1'b1, 16'h000C, 32'h11111111, 4'hF, rd, lat, nack, leak);
    xfer(0, 1'b0, 16'h000C, 32'h0, 4'hF, rd, lat, nack, leak);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL rst_pre_rdata got %08h want %08h", rd, ex);
    end
    // Read accepted, then reset lands on the edge that would raise ack.
    @(negedge clk);
    adr = 16'h000C; we = 1'b0; sel = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ack[0] !== 1'b0) begin
      errors++; $display("FAIL rst_ack_suppressed got %0b want 0", ack[0]);
    end
    checks++;
    if (dout[0] !== 32'h0) begin
      errors++; $display("FAIL rst_dat_zero got %08h want 00000000", dout[0]);
    end
    reset = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    // Write pending in WAIT when reset arrives: no ack may follow.
    @(negedge clk);
    adr = 16'h0014; dat = 32'h22222222; we = 1'b1; sel = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    nack = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2]) nack++;
    end
    checks++;
    if (nack !== 0) begin
      errors++; $display("FAIL rst_wait_ack got %0d acks want 0", nack);
    end
    exp_q.push_back(32'h0);
    xfer(0, 1'b0, 16'h000C, 32'h0, 4'hF, rd, lat, nack, leak);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL rst_post_rdata got %08h want %08h", rd, ex);
    end
    exp_q.push_back(32'h0);
    xfer(2, 1'b0, 16'h0014, 32'h0, 4'hF, rd, lat, nack, leak);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++; $display("FAIL rst_wait_rdata got %08h want %08h", rd, ex);
    end
  endtask

  initial begin
    reset = 1'b1;
    adr = '0; dat = '0; we = 1'b0; sel = '0;
    cyc = '0; stb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_ws0_transfers();
    test_wait_states();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
